uart_ram_loader: RTL and testbench

//  Pulls a byte stream from the board CPLD UART and packs pairs into 16-bit words (low byte first).

---
 rtl/uart_ram_pkg.sv | 24 ++
 rtl/uart_rx_port.sv | 71 +++++++
 rtl/uart_ram_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ram_pkg.sv
// Shared definitions for the UART-to-RAM2 loader.
// Contents:
//   DefAddrW : default RAM2 word-address width
//   RAM_OFF  : inactive level for the active-low RAM control strobes
//   state_e  : loader FSM state encoding
package uart_ram_pkg;

  localparam int unsigned DefAddrW = 18;
  localparam logic        RAM_OFF  = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StWaitRx,
    StRdStrobe,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StEchoWait,
    StEchoSetup,
    StEchoPulse,
    StDone
  } state_e;

endpackage

// File: rtl/uart_rx_port.sv
// Byte reader for the CPLD UART.
// When the loader requests a byte and the UART reports data_ready, rdn is pulled low for RD_LOW
// cycles. bus_din is captured on the last low cycle; byte_valid pulses in the cycle after rdn
// returns high, and rx_byte holds that byte until the next read.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rd_req      : loader is waiting for a byte
//   data_ready  : UART has a received byte
//   bus_din     : shared RAM1/UART data bus, read side
//   rdn         : UART read strobe, active low
//   byte_valid  : 1-cycle pulse, rx_byte was just captured
//   rx_byte     : last captured byte
module uart_rx_port #(
  parameter int unsigned RD_LOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       data_ready,
  input  logic [7:0] bus_din,
  output logic       rdn,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  localparam int unsigned CntW = (RD_LOW > 1) ? $clog2(RD_LOW) : 1;

  logic            rdn_q, rdn_d;
  logic            valid_q, valid_d;
  logic [7:0]      byte_q, byte_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    rdn_d   = rdn_q;
    valid_d = 1'b0;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    if (rdn_q) begin
      if (rd_req && data_ready) begin
        rdn_d = 1'b0;
        cnt_d = CntW'(RD_LOW - 1);
      end
    end else if (cnt_q == '0) begin
      // Last low cycle: the UART is driving the bus now.
      rdn_d   = 1'b1;
      byte_d  = bus_din;
      valid_d = 1'b1;
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q   <= 1'b1;
      valid_q <= 1'b0;
      byte_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rdn_q   <= rdn_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdn        = rdn_q;
  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Loads a byte stream from the CPLD UART into RAM2 as 16-bit words (low byte first), at
// consecutive word addresses from a latched base (wrapping modulo 2**ADDR_W).
// RAM1 is held disabled so the shared RAM1/UART data bus belongs to the UART.
// Optional feature: define UART_ECHO_EN to echo every received byte back through the UART
// (waits for tbre & tsre, drives bus_dout, pulses wrn). Undefined: wrn=1, bus_drive=0.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : 1-cycle pulse, begins a load when idle
//   base_addr, word_count  : first RAM2 word address, number of words
//   data_ready, tbre, tsre : UART status
//   bus_din / bus_dout     : shared bus read side / echo byte; bus_drive enables the tri-state
//   rdn, wrn               : UART read / write strobes, active low
//   ram1_en/oe/we          : RAM1 controls, held inactive
//   ram2_addr, ram2_dout   : RAM2 address and write data; ram2_drive enables the data tri-state
//   ram2_en/oe/we          : RAM2 controls, active low
//   busy, done             : load in progress / 1-cycle completion pulse
//   words_loaded           : words written in the current or last load
module uart_ram_loader
  import uart_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned RD_LOW = 2,
  parameter int unsigned WE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  input  logic [7:0]        bus_din,
  output logic [7:0]        bus_dout,
  output logic              bus_drive,
  output logic              rdn,
  output logic              wrn,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic [ADDR_W-1:0] ram2_addr,
  output logic [15:0]       ram2_dout,
  output logic              ram2_drive,
  output logic              ram2_en,
  output logic              ram2_oe,
  output logic              ram2_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int unsigned WeCntW = (WE_LOW > 1) ? $clog2(WE_LOW) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [7:0]          lo_q, lo_d;
  logic                lo_got_q, lo_got_d;
  logic                hi_got_q, hi_got_d;
  logic [WeCntW-1:0]   cnt_q, cnt_d;
  logic                echo_hold_q, echo_hold_d;

  logic       rd_req;
  logic       byte_valid;
  logic [7:0] rx_byte;

  assign rd_req = (state_q == StWaitRx);

  uart_rx_port #(
    .RD_LOW (RD_LOW)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .data_ready (data_ready),
    .bus_din    (bus_din),
    .rdn        (rdn),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    words_d     = words_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    lo_got_d    = lo_got_q;
    hi_got_d    = hi_got_q;
    cnt_d       = cnt_q;
    echo_hold_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = word_count;
          words_d  = '0;
          lo_got_d = 1'b0;
          hi_got_d = 1'b0;
          state_d  = (word_count == '0) ? StDone : StWaitRx;
        end
      end
      StWaitRx: begin
        if (data_ready) state_d = StRdStrobe;
      end
      StRdStrobe: begin
        if (byte_valid) begin
          if (!lo_got_q) begin
            lo_d     = rx_byte;
            lo_got_d = 1'b1;
          end else begin
            hi_got_d = 1'b1;
          end
`ifdef UART_ECHO_EN
          state_d = StEchoWait;
`else
          if (lo_got_q) begin
            state_d = StWrSetup;
            addr_d  = base_q + words_q;
            wdata_d = {rx_byte, lo_q};
          end else begin
            state_d = StWaitRx;
          end
`endif
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = WeCntW'(WE_LOW - 1);
      end
      StWrPulse: begin
        if (cnt_q == '0) state_d = StWrHold;
        else             cnt_d   = cnt_q - WeCntW'(1);
      end
      StWrHold: begin
        words_d  = words_q + ADDR_W'(1);
        lo_got_d = 1'b0;
        hi_got_d = 1'b0;
        state_d  = (words_d == count_q) ? StDone : StWaitRx;
      end
`ifdef UART_ECHO_EN
      StEchoWait: begin
        if (tbre && tsre) state_d = StEchoSetup;
      end
      StEchoSetup: begin
        state_d = StEchoPulse;
      end
      StEchoPulse: begin
        // Keep the bus driven one more cycle so the data outlives the wrn rising edge.
        echo_hold_d = 1'b1;
        if (hi_got_q) begin
          state_d = StWrSetup;
          addr_d  = base_q + words_q;
          wdata_d = {rx_byte, lo_q};
        end else begin
          state_d = StWaitRx;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      count_q     <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      lo_got_q    <= 1'b0;
      hi_got_q    <= 1'b0;
      cnt_q       <= '0;
      echo_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      lo_got_q    <= lo_got_d;
      hi_got_q    <= hi_got_d;
      cnt_q       <= cnt_d;
      echo_hold_q <= echo_hold_d;
    end
  end

  logic in_write;
  assign in_write = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);

  assign ram1_en      = RAM_OFF;
  assign ram1_oe      = RAM_OFF;
  assign ram1_we      = RAM_OFF;
  assign ram2_oe      = RAM_OFF;
  assign ram2_en      = !in_write;
  assign ram2_drive   = in_write;
  assign ram2_we      = (state_q != StWrPulse);
  assign ram2_addr    = addr_q;
  assign ram2_dout    = wdata_q;
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign words_loaded = words_q;

`ifdef UART_ECHO_EN
  assign wrn       = (state_q != StEchoPulse);
  assign bus_drive = (state_q == StEchoSetup) || (state_q == StEchoPulse) || echo_hold_q;
  assign bus_dout  = rx_byte;
`else
  assign wrn       = 1'b1;
  assign bus_drive = 1'b0;
  assign bus_dout  = '0;
  logic unused_echo;
  assign unused_echo = ^{tbre, tsre, hi_got_q, echo_hold_q};
`endif

endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader: a UART byte-source model, a write scoreboard
// (expected RAM2 writes queued at stimulus time, popped on each ram2_we falling edge) and
// one task per scenario.
module tb_uart_ram_loader;

  localparam int RdLow = 2;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk, rst, start, data_ready, tbre, tsre;
  logic [17:0] base_addr, word_count;
  logic [7:0]  bus_din, bus_dout;
  logic        bus_drive, rdn, wrn, ram1_en, ram1_oe, ram1_we;
  logic [17:0] ram2_addr, words_loaded;
  logic [15:0] ram2_dout;
  logic        ram2_drive, ram2_en, ram2_oe, ram2_we, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, we_events = 0, rd_events = 0, wrn_events = 0, overlap = 0, rd_len = 0;
  logic we_prev = 1'b1, rdn_prev = 1'b1;
  wr_t exp_q[$];
  logic [7:0] tx_q[$];

  uart_ram_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .data_ready   (data_ready),
    .tbre         (tbre),
    .tsre         (tsre),
    .bus_din      (bus_din),
    .bus_dout     (bus_dout),
    .bus_drive    (bus_drive),
    .rdn          (rdn),
    .wrn          (wrn),
    .ram1_en      (ram1_en),
    .ram1_oe      (ram1_oe),
    .ram1_we      (ram1_we),
    .ram2_addr    (ram2_addr),
    .ram2_dout    (ram2_dout),
    .ram2_drive   (ram2_drive),
    .ram2_en      (ram2_en),
    .ram2_oe      (ram2_oe),
    .ram2_we      (ram2_we),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: scoreboard pop on each write strobe, strobe-length and bus-rule checks.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      rd_len = 0;
    end else begin
      if (ram2_we === 1'b0 && we_prev === 1'b1) begin
        wr_t e;
        we_events++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_write: got addr=%h data=%h, required no write", ram2_addr,
                   ram2_dout);
        end else begin
          e = exp_q.pop_front();
          if ({ram2_addr, ram2_dout, ram2_en, ram2_drive} !== {e.addr, e.data, 2'b01}) begin
            n_err++;
            $display("FAIL ram2_write: got addr=%h data=%h en=%b drv=%b, required %h %h 0 1",
                     ram2_addr, ram2_dout, ram2_en, ram2_drive, e.addr, e.data);
          end
        end
      end
      if (rdn === 1'b0) rd_len++;
      if (rdn === 1'b1 && rdn_prev === 1'b0) begin
        rd_events++;
        n_cmp++;
        if (rd_len !== RdLow) begin
          n_err++;
          $display("FAIL rdn_low_len: got %0d cycles, required %0d", rd_len, RdLow);
        end
        rd_len = 0;
      end
      if (bus_drive === 1'b1 && rdn === 1'b0) overlap++;
      if (done === 1'b1) done_cnt++;
      if (wrn === 1'b0) wrn_events++;
    end
    we_prev  = ram2_we;
    rdn_prev = rdn;
  end

  task automatic pulse_start(input logic [17:0] b, input logic [17:0] c);
    @(negedge clk);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string name);
    bit ok = 0;
    bus_din    = b;
    data_ready = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdn === 1'b0) ok = 1;
    end
    data_ready = 1'b0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (rdn === 1'b1) ok = 1;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_read_timeout: byte %h read strobe got none, required full rdn pulse",
               name, b);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done_timeout: done got 0, required 1 within 400 cycles", name);
    end
  endtask

  // Loads the bytes in tx_q as count words at base, checking the completion state.
  task automatic run_load(input logic [17:0] base, input int count, input string name);
    int d0 = done_cnt;
    for (int i = 0; i < count; i++) begin
      wr_t w;
      w.addr = base + 18'(i);
      w.data = {tx_q[2*i+1], tx_q[2*i]};
      exp_q.push_back(w);
    end
    pulse_start(base, 18'(count));
    for (int i = 0; i < 2 * count; i++) send_byte(tx_q[i], name);
    wait_done(name);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt - d0);
    end
    n_cmp++;
    if (words_loaded !== 18'(count) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_final: got words_loaded=%0d busy=%b, required %0d 0", name,
               words_loaded, busy, count);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s_writes_missing: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rdn, wrn, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we} !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, required 11111111",
               {rdn, wrn, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we});
    end
    n_cmp++;
    if ({bus_drive, ram2_drive, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 0000", {bus_drive, ram2_drive, busy, done});
    end
    n_cmp++;
    if ({bus_dout, ram2_addr, ram2_dout, words_loaded} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got dout=%h addr=%h wdata=%h words=%h, required all 0",
               bus_dout, ram2_addr, ram2_dout, words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    tx_q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    run_load(18'h00100, 2, "basic");
  endtask

  task automatic test_zero_count();
    int r0 = rd_events, w0 = we_events, d0 = done_cnt;
    pulse_start(18'h01234, 18'd0);
    wait_done("zero");
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rd_events - r0 !== 0 || we_events - w0 !== 0) begin
      n_err++;
      $display("FAIL zero_activity: got %0d reads %0d writes, required 0 0", rd_events - r0,
               we_events - w0);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || words_loaded !== 18'd0) begin
      n_err++;
      $display("FAIL zero_done: got pulses=%0d words=%0d, required 1 0", done_cnt - d0,
               words_loaded);
    end
  endtask

  task automatic test_wrap();
    tx_q = '{8'h01, 8'hF0, 8'h5A, 8'h3C};
    run_load(18'h3FFFF, 2, "wrap");
  endtask

  task automatic test_stall();
    bit quiet = 1;
    int w0;
    wr_t w;
    pulse_start(18'h00300, 18'd1);
    send_byte(8'h11, "stall");
    w0 = we_events;
    repeat (50) begin
      @(negedge clk);
      if (rdn !== 1'b1 || ram2_we !== 1'b1 || busy !== 1'b1) quiet = 0;
    end
    n_cmp++;
    if (!quiet || we_events !== w0) begin
      n_err++;
      $display("FAIL stall_quiet: got quiet=%b writes=%0d, required 1 0", quiet,
               we_events - w0);
    end
    w.addr = 18'h00300;
    w.data = 16'h2211;
    exp_q.push_back(w);
    send_byte(8'h22, "stall");
    wait_done("stall");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0 || words_loaded !== 18'd1) begin
      n_err++;
      $display("FAIL stall_final: got pending=%0d words=%0d, required 0 1", exp_q.size(),
               words_loaded);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(18'h00ABC, 18'd1);
    send_byte(8'h77, "rstmid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rdn, wrn, ram2_en, ram2_we, bus_drive, ram2_drive, busy, done} !== 8'b11110000) begin
      n_err++;
      $display("FAIL rstmid_ctrl: got %b, required 11110000",
               {rdn, wrn, ram2_en, ram2_we, bus_drive, ram2_drive, busy, done});
    end
    n_cmp++;
    if ({ram2_addr, ram2_dout, words_loaded, bus_dout} !== '0) begin
      n_err++;
      $display("FAIL rstmid_data: got addr=%h wdata=%h words=%h, required 0 0 0", ram2_addr,
               ram2_dout, words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
    tx_q = '{8'h55, 8'hAA};
    run_load(18'h00ABC, 1, "restart");
  endtask

`ifdef UART_ECHO_EN
  task automatic test_echo();
    bit wrn_hi = 1;
    bit seen = 0;
    wr_t w;
    w.addr = 18'h00200;
    w.data = 16'hA55A;
    exp_q.push_back(w);
    tbre = 1'b0;
    pulse_start(18'h00200, 18'd1);
    send_byte(8'h5A, "echo");
    repeat (20) begin
      @(negedge clk);
      if (wrn !== 1'b1) wrn_hi = 0;
    end
    n_cmp++;
    if (wrn_hi !== 1'b1) begin
      n_err++;
      $display("FAIL echo_wait: got wrn low while tbre=0, required wrn=1");
    end
    tbre = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wrn === 1'b0) begin
        seen = 1;
        n_cmp++;
        if (bus_dout !== 8'h5A || bus_drive !== 1'b1) begin
          n_err++;
          $display("FAIL echo_byte: got dout=%h drive=%b, required 5a 1", bus_dout, bus_drive);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL echo_pulse: got no wrn pulse, required one");
    end
    send_byte(8'hA5, "echo");
    wait_done("echo");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL echo_write: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`else
  task automatic test_echo();
    n_cmp++;
    if (wrn_events !== 0) begin
      n_err++;
      $display("FAIL no_echo_wrn: got %0d wrn low cycles, required 0", wrn_events);
    end
  endtask
`endif

  task automatic test_bus_rules();
    n_cmp++;
    if (overlap !== 0) begin
      n_err++;
      $display("FAIL bus_overlap: got %0d cycles with bus_drive and rdn low, required 0",
               overlap);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    data_ready = 1'b0;
    tbre       = 1'b1;
    tsre       = 1'b1;
    base_addr  = '0;
    word_count = '0;
    bus_din    = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_echo();
    test_bus_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
